// File: rtl/ring_decoder_pkg.sv
// Shared definitions for the ring decoder: state encodings, default sizes and bench clock macros.
// Optional wrap counter is enabled with RING_DECODER_WRAPCNT_EN.
`ifndef RD_CLK_PERIOD
`define RD_CLK_PERIOD 10
`endif
`ifndef RD_CLK_HALF
`define RD_CLK_HALF 5
`endif

package ring_decoder_pkg;

  localparam int unsigned RD_N_DEFAULT  = 8;
  localparam int unsigned RD_CW_DEFAULT = 8;

  typedef enum logic [1:0] {
    RD_SYNC  = 2'd0,
    RD_TRACK = 2'd1,
    RD_FAULT = 2'd2
  } rd_state_t;

endpackage

// File: rtl/ring_decoder_onehot_encoder.sv
// Combinational one-hot to binary encoder with an exactly-one-bit-set flag.
module onehot_encoder
  import ring_decoder_pkg::*;
#(
  parameter int unsigned N  = RD_N_DEFAULT,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  word,
  output logic [IW-1:0] pos,
  output logic          is_onehot
);

  always_comb begin
    pos = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (word[i]) begin
        pos = pos | IW'(i);
      end
    end
    // Clearing the lowest set bit leaves zero only for a single-bit word
    is_onehot = (word != '0) && ((word & (word - N'(1))) == '0);
  end

endmodule

// File: rtl/ring_decoder.sv
// Ring phase decoder and integrity monitor: binary index, wrap pulse, error pulses, sticky fault.
// Define RING_DECODER_WRAPCNT_EN to add the wrap_count port and counter.
module ring_decoder
  import ring_decoder_pkg::*;
#(
  parameter int unsigned N  = RD_N_DEFAULT,
  parameter int unsigned IW = $clog2(N),
  parameter int unsigned CW = RD_CW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clear,
  input  logic [N-1:0]  ring,
  output logic [IW-1:0] idx,
  output logic          valid,
  output logic          wrap,
  output logic          err_onehot,
  output logic          err_seq,
  output logic          fault
`ifdef RING_DECODER_WRAPCNT_EN
  ,
  output logic [CW-1:0] wrap_count
`endif
);

  rd_state_t     state;
  logic [IW-1:0] pos;
  logic          is_onehot;
  logic [IW-1:0] idx_next;

  onehot_encoder #(.N(N), .IW(IW)) u_enc (
    .word      (ring),
    .pos       (pos),
    .is_onehot (is_onehot)
  );

  always_comb begin
    idx_next = (idx == IW'(N - 1)) ? '0 : IW'(idx + 1'b1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RD_SYNC;
      idx        <= '0;
      valid      <= 1'b0;
      wrap       <= 1'b0;
      err_onehot <= 1'b0;
      err_seq    <= 1'b0;
      fault      <= 1'b0;
`ifdef RING_DECODER_WRAPCNT_EN
      wrap_count <= '0;
`endif
    end else begin
      wrap       <= 1'b0;
      err_onehot <= 1'b0;
      err_seq    <= 1'b0;
      if (clear) begin
        state <= RD_SYNC;
        idx   <= '0;
        valid <= 1'b0;
        fault <= 1'b0;
`ifdef RING_DECODER_WRAPCNT_EN
        wrap_count <= '0;
`endif
      end else if (en) begin
        case (state)
          RD_SYNC: begin
            if (is_onehot) begin
              idx   <= pos;
              valid <= 1'b1;
              state <= RD_TRACK;
            end
          end
          RD_TRACK: begin
            if (!is_onehot) begin
              err_onehot <= 1'b1;
              fault      <= 1'b1;
              valid      <= 1'b0;
              state      <= RD_FAULT;
            end else if (pos == idx) begin
              state <= RD_TRACK;
            end else if (pos == idx_next) begin
              idx <= pos;
              if (idx == IW'(N - 1)) begin
                wrap <= 1'b1;
`ifdef RING_DECODER_WRAPCNT_EN
                wrap_count <= wrap_count + 1'b1;
`endif
              end
            end else begin
              err_seq <= 1'b1;
              fault   <= 1'b1;
              valid   <= 1'b0;
              state   <= RD_FAULT;
            end
          end
          RD_FAULT: begin
            state <= RD_FAULT;
          end
          default: begin
            state <= RD_SYNC;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ring_decoder.md
# ring_decoder

Receive-side companion to the one-hot ring counter: samples an N-bit ring phase bus, converts it to a binary phase index, and checks that the sequence is a legal rotation. It flags non-one-hot words and illegal jumps, reports wrap-around of the ring, and latches a sticky fault until software or control logic clears it. It sits on the consumer side of any ring-counter-driven sequencer and serves as that counter's runtime integrity monitor.

## Interface
- N, 8, ring width (number of phases), N >= 2
- IW, $clog2(N), index width
- CW, 8, wrap counter width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  sample enable; ring is evaluated only on cycles with en=1
- clear  in  1  synchronous fault clear / resynchronise request
- ring  in  N  one-hot phase word from the ring counter
- idx  out  IW  binary position of the active bit of the last accepted word
- valid  out  1  decoder is locked and idx is meaningful
- wrap  out  1  one-cycle pulse: accepted transition from phase N-1 to phase 0
- err_onehot  out  1  one-cycle pulse: sampled word had zero or more than one bit set
- err_seq  out  1  one-cycle pulse: legal one-hot word but illegal transition
- fault  out  1  sticky error flag
- wrap_count  out  CW  wraps since reset/clear (present only with RING_DECODER_WRAPCNT_EN)

## Operation
- States: SYNC, TRACK, FAULT. SYNC on reset.
- SYNC: on en with a one-hot ring, load idx=pos(ring), set valid=1, go to TRACK. A non-one-hot word in SYNC is ignored (no error pulse).
- TRACK, on en:
  - non-one-hot word: err_onehot=1, go to FAULT.
  - pos == idx: stall, accepted, no change.
  - pos == (idx+1) mod N: idx=pos; if idx was N-1, wrap=1 and wrap_count increments.
  - any other pos: err_seq=1, go to FAULT; idx holds the last good value.
- FAULT: valid=0, fault=1, idx frozen, en ignored. Only clear or reset exits.
- clear (any state): go to SYNC; valid=0, fault=0, wrap_count=0, idx=0. clear overrides en, and ring is not evaluated that cycle.
- en=0: state, idx, valid, fault and wrap_count hold; pulse outputs are 0.
- wrap_count rolls over modulo 2^CW; no saturation.
- err_onehot and err_seq are never both 1 in the same cycle.

## Timing
- All outputs are registered. A decision on the ring value sampled at edge k is visible after edge k; latency is 1 cycle.
- Reset values: idx=0, valid=0, wrap=0, err_onehot=0, err_seq=0, fault=0, wrap_count=0, state=SYNC.
- Pulse outputs are high for exactly one cycle after the triggering edge.
- fault rises in the same cycle as the error pulse. valid falls in that cycle too.
- Reset asserted mid-operation immediately forces the reset values, with no clock needed. After deassertion the block resynchronises from SYNC.
- ring needs no synchronisation; it comes from the same clock domain.

## Configuration
- RING_DECODER_WRAPCNT_EN defined: the wrap_count port and counter exist as specified.
- RING_DECODER_WRAPCNT_EN undefined: the wrap_count port and register are removed. The wrap pulse is still generated, and all other behaviour is unchanged.

## Structure
- Shared defs include holds:
  - the state encodings (RD_SYNC=2'd0, RD_TRACK=2'd1, RD_FAULT=2'd2);
  - the default N and CW constants;
  - the existing clock macros used by benches.
- Sub-module onehot_encoder (combinational): N-bit input, IW-bit pos output, and an is_onehot flag (exactly one bit set). The FSM and registers live in ring_decoder.

## Test plan
- Lock and rotate: reset 10 cycles. Then, with en=1, drive 8'h01, 02, 04, …, 80, 01 with N=8. Required: valid=1 one cycle after 8'h01. idx steps 0..7 then 0. wrap pulses once after 8'h01 follows 8'h80. wrap_count=1.
- Stall: in TRACK at idx=3, hold ring=8'h08 for 5 cycles. Required: idx stays 3, valid=1, no error pulses.
- Non-one-hot: in TRACK at idx=2, drive 8'h0C. Required: err_onehot pulses one cycle, fault=1, valid=0, idx=2. Later legal words leave the state unchanged.
- Illegal jump: in TRACK at idx=1, drive 8'h10. Required: err_seq pulses, fault=1, idx=1. Then assert clear and drive 8'h10. Required: SYNC, fault=0, wrap_count=0. The next en cycle locks at idx=4.
- Enable gating and async reset: with en=0, drive garbage such as 8'hFF. Required: no change and no pulses. Then assert reset between clock edges. Required: all outputs go to their reset values before the next edge.
